// File: rtl/gray_decoder_pipe.sv
// Gray-to-binary decoder: two-stage valid/ready pipeline, parameterised width.
// Optional one-bit-step checker enabled by defining GRAY_STEP_CHECK_EN.
module gray_decoder_pipe #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    // XOR-prefix from the MSB down
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_gray;
    logic             s1_adv_c;
    logic             s2_adv_c;
    logic             in_accept_c;

    assign s2_adv_c    = !out_valid || out_ready;
    assign s1_adv_c    = !s1_valid || s2_adv_c;
    assign in_ready    = s1_adv_c;
    assign in_accept_c = in_valid && s1_adv_c;

    // Stage 1: capture raw Gray code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_gray  <= '0;
        end else if (s1_adv_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_gray <= in_gray;
            end
        end
    end

    // Stage 2: decoded result drives the output side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bin   <= '0;
        end else if (s2_adv_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_bin <= gray2bin(s1_gray);
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic             has_prev;
    logic             s1_err;
    logic [WIDTH-1:0] diff_c;
    logic             step_bad_c;

    // More than one bit set <=> x & (x-1) is non-zero
    assign diff_c     = prev_gray ^ in_gray;
    assign step_bad_c = has_prev && ((diff_c & (diff_c - WIDTH'(1))) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray <= '0;
            has_prev  <= 1'b0;
            s1_err    <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
        end else begin
            if (in_accept_c) begin
                prev_gray <= in_gray;
                has_prev  <= 1'b1;
            end
            if (s1_adv_c) begin
                s1_err <= in_valid && step_bad_c;
            end
            if (s2_adv_c) begin
                step_err <= s1_valid && s1_err;
            end
            if (out_valid && out_ready && step_err && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = in_accept_c;

    // Counter width only matters when the step checker is built
    if (ERR_CNT_W == 0) begin : g_no_err_cnt
    end
`endif

endmodule

// File: tb/tb_gray_decoder_pipe.sv
// Directed bench for gray_decoder_pipe (WIDTH=3 and WIDTH=8 instances).
// Step-checker cases run only when GRAY_STEP_CHECK_EN is defined.
module tb_gray_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_gray;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_bin;

    logic       in_valid8;
    logic       in_ready8;
    logic [7:0] in_gray8;
    logic       out_valid8;
    logic       out_ready8;
    logic [7:0] out_bin8;

`ifdef GRAY_STEP_CHECK_EN
    logic       step_err;
    logic [1:0] err_count;
    logic       step_err8;
    logic [7:0] err_count8;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_decoder_pipe #(.WIDTH(3), .ERR_CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin)
`ifdef GRAY_STEP_CHECK_EN
        , .step_err(step_err), .err_count(err_count)
`endif
    );

    gray_decoder_pipe #(.WIDTH(8), .ERR_CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_gray(in_gray8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_bin(out_bin8)
`ifdef GRAY_STEP_CHECK_EN
        , .step_err(step_err8), .err_count(err_count8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
`ifdef GRAY_STEP_CHECK_EN
    logic [2:0] seq5 [4] = '{3'b000, 3'b011, 3'b010, 3'b010};
    logic       err5 [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_gray    = '0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        in_gray8   = '0;
        out_ready8 = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bin", 32'(out_bin), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back stream decodes to 0..7, one edge after accept
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_gray  = seq[k];
            tick();
            if (k >= 1) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check($sformatf("stream_bin%0d", k - 1), 32'(out_bin), 32'(k - 1));
            end
            check("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_last", 32'(out_bin), 32'd7);
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: two beats held, then released in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_gray   = 3'b011;
        tick();
        in_gray = 3'b110;
        tick();
        in_valid = 1'b0;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_hold_bin", 32'(out_bin), 32'd2);
        tick();
        check("bp_hold_bin2", 32'(out_bin), 32'd2);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", 32'(in_ready), 32'd1);
        tick();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_bin", 32'(out_bin), 32'd4);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Full with simultaneous accept + emit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_gray   = 3'b001;
        tick();
        in_gray = 3'b011;
        tick();
        out_ready = 1'b1;
        in_gray   = 3'b111;
        #1;
        check("thru_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("thru_bin1", 32'(out_bin), 32'd2);
        tick();
        check("thru_bin2", 32'(out_bin), 32'd5);
        tick();
        check("thru_valid_end", 32'(out_valid), 32'd0);

        // Async reset while full discards in-flight beats
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_gray   = 3'b010;
        tick();
        in_gray = 3'b110;
        tick();
        in_valid = 1'b0;
        check("rst_mid_full", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_bin", 32'(out_bin), 32'd0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        tick();
        check("rst_no_stale", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_gray  = 3'b101;
        tick();
        in_valid = 1'b0;
        check("rst_no_stale2", 32'(out_valid), 32'd0);
        tick();
        check("rst_next_valid", 32'(out_valid), 32'd1);
        check("rst_next_bin", 32'(out_bin), 32'd6);

        // WIDTH=8 boundary codes
        in_valid8 = 1'b1;
        in_gray8  = 8'hFF;
        tick();
        in_gray8 = 8'h80;
        tick();
        check("w8_ff", 32'(out_bin8), 32'hAA);
        in_valid8 = 1'b0;
        tick();
        check("w8_80", 32'(out_bin8), 32'hFF);
        check("w8_valid", 32'(out_valid8), 32'd1);

`ifdef GRAY_STEP_CHECK_EN
        do_reset();
        check("chk_rst_cnt", 32'(err_count), 32'd0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_gray  = seq5[k];
            tick();
            if (k >= 1) check($sformatf("chk_err%0d", k - 1), 32'(step_err), 32'(err5[k-1]));
        end
        in_valid = 1'b0;
        tick();
        check("chk_err3", 32'(step_err), 32'd0);
        tick();
        check("chk_idle_err", 32'(step_err), 32'd0);
        check("chk_cnt1", 32'(err_count), 32'd1);

        do_reset();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_gray  = k[0] ? 3'b011 : 3'b000;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("chk_cnt_sat", 32'(err_count), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
